// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser, lock-out FSM and long-press timer.
// Optional interrupt aggregation (pending/irq) is compiled in with `define MULTI_DEBOUNCER_IRQ_EN.
module multi_debouncer #(
    parameter int CHANNELS   = 8,
    parameter int DELAY      = 1500000,
    parameter int CNT_W      = 21,
    parameter int HOLD_DELAY = 50000000,
    parameter int HOLD_W     = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic                any_event
`ifdef MULTI_DEBOUNCER_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] irq_mask,
    input  logic [CHANNELS-1:0] irq_clear,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
`endif
);

    localparam logic [CNT_W-1:0]  LOCK_INIT = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_DELAY);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    logic [CHANNELS-1:0] event_d;
    logic                any_event_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic              s1_q, s2_q;
            state_t            state_q;
            logic [CNT_W-1:0]  cnt_q;
            logic [HOLD_W-1:0] hold_cnt_q;
            logic              level_q, rise_q, fall_q, hold_q;
            logic              accept_d, level_d, rise_d, fall_d, hold_d;

            always_comb begin
                accept_d = (state_q == IDLE) && (s2_q != level_q);
                level_d  = accept_d ? s2_q : level_q;
                rise_d   = accept_d && s2_q;
                fall_d   = accept_d && !s2_q;
                // level_d gate lets a fall landing on the hold cycle cancel the pulse
                hold_d   = level_q && level_d && (hold_cnt_q == HOLD_LAST);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_q       <= 1'b0;
                    s2_q       <= 1'b0;
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    hold_cnt_q <= '0;
                    level_q    <= 1'b0;
                    rise_q     <= 1'b0;
                    fall_q     <= 1'b0;
                    hold_q     <= 1'b0;
                end else begin
                    s1_q    <= in_data[gi];
                    s2_q    <= s1_q;
                    level_q <= level_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                    hold_q  <= hold_d;
                    case (state_q)
                        IDLE: begin
                            if (accept_d) begin
                                state_q <= LOCK;
                                cnt_q   <= LOCK_INIT;
                            end
                        end
                        LOCK: begin
                            // Leaving at count 1 makes the next edge acceptable exactly DELAY cycles later
                            if (cnt_q <= LOCK_LAST) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                    if (!level_q) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
            end

            assign event_d[gi] = rise_d | fall_d | hold_d;
            assign level[gi]   = level_q;
            assign rise[gi]    = rise_q;
            assign fall[gi]    = fall_q;
            assign hold[gi]    = hold_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= |event_d;
        end
    end

    assign any_event = any_event_q;

`ifdef MULTI_DEBOUNCER_IRQ_EN
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic                irq_q;

    // Set has priority over clear so an event coinciding with a clear is never lost
    always_comb begin
        pending_d = (pending_q & ~irq_clear) | ((rise | fall | hold) & irq_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_q;
        end
    end

    assign pending = pending_q;
    assign irq     = irq_q;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: two instances (DELAY=4 and DELAY=8) driven from shared stimulus.
// Cycle c counts clock edges since the scenario's reset release; inputs change just after edge c.
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_data;
    logic [1:0] level_a, rise_a, fall_a, hold_a;
    logic [1:0] level_b, rise_b, fall_b, hold_b;
    logic       any_a, any_b;
`ifdef MULTI_DEBOUNCER_IRQ_EN
    logic [1:0] irq_mask, irq_clear, pending_a, pending_b;
    logic       irq_a, irq_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int c        = 0;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(2), .DELAY(4), .CNT_W(4), .HOLD_DELAY(10), .HOLD_W(5)
    ) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data),
        .level(level_a), .rise(rise_a), .fall(fall_a), .hold(hold_a),
        .any_event(any_a)
`ifdef MULTI_DEBOUNCER_IRQ_EN
        , .irq_mask(irq_mask), .irq_clear(irq_clear), .pending(pending_a), .irq(irq_a)
`endif
    );

    multi_debouncer #(
        .CHANNELS(2), .DELAY(8), .CNT_W(4), .HOLD_DELAY(10), .HOLD_W(5)
    ) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data),
        .level(level_b), .rise(rise_b), .fall(fall_b), .hold(hold_b),
        .any_event(any_b)
`ifdef MULTI_DEBOUNCER_IRQ_EN
        , .irq_mask(irq_mask), .irq_clear(irq_clear), .pending(pending_b), .irq(irq_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s c=%0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic start(input string name);
        reset   = 1'b1;
        in_data = 2'b00;
`ifdef MULTI_DEBOUNCER_IRQ_EN
        irq_mask  = 2'b00;
        irq_clear = 2'b00;
`endif
        repeat (3) tick();
        check({name, "_rst_level"}, {30'd0, level_a}, 32'd0);
        check({name, "_rst_pulses"}, {25'd0, rise_a, fall_a, hold_a, any_a}, 32'd0);
        reset = 1'b0;
        c     = 0;
        $display("scenario %s", name);
    endtask

    initial begin
        // Clean rise on ch0, ch1 idle
        start("s1");
        for (int k = 0; k < 20; k++) begin
            if (c == 10) in_data = 2'b01;
            tick();
            check("s1_level", {30'd0, level_a}, (c >= 13) ? 32'd1 : 32'd0);
            check("s1_rise", {30'd0, rise_a}, (c == 13) ? 32'd1 : 32'd0);
            check("s1_fall", {30'd0, fall_a}, 32'd0);
            check("s1_any", {31'd0, any_a}, (c == 13) ? 32'd1 : 32'd0);
        end

        // Bounce inside the DELAY=8 lock window is ignored
        start("s2");
        for (int k = 0; k < 26; k++) begin
            case (c)
                10: in_data = 2'b01;
                14: in_data = 2'b00;
                15: in_data = 2'b01;
                16: in_data = 2'b00;
                17: in_data = 2'b01;
                default: ;
            endcase
            tick();
            check("s2_level", {30'd0, level_b}, (c >= 13) ? 32'd1 : 32'd0);
            check("s2_rise", {30'd0, rise_b}, (c == 13) ? 32'd1 : 32'd0);
            check("s2_fall", {30'd0, fall_b}, 32'd0);
        end

        // Fall during lock is taken on the first idle cycle
        start("s3");
        for (int k = 0; k < 24; k++) begin
            if (c == 10) in_data = 2'b01;
            if (c == 12) in_data = 2'b00;
            tick();
            check("s3_level", {30'd0, level_a}, (c >= 13 && c < 17) ? 32'd1 : 32'd0);
            check("s3_rise", {30'd0, rise_a}, (c == 13) ? 32'd1 : 32'd0);
            check("s3_fall", {30'd0, fall_a}, (c == 17) ? 32'd1 : 32'd0);
        end

        // Long press: hold fires once, 10 cycles after rise
        start("s4a");
        for (int k = 0; k < 36; k++) begin
            if (c == 10) in_data = 2'b01;
            tick();
            check("s4a_hold", {30'd0, hold_a}, (c == 23) ? 32'd1 : 32'd0);
            check("s4a_any", {31'd0, any_a}, (c == 13 || c == 23) ? 32'd1 : 32'd0);
        end

        // Release 5 cycles after rise cancels the hold
        start("s4b");
        for (int k = 0; k < 36; k++) begin
            if (c == 10) in_data = 2'b01;
            if (c == 15) in_data = 2'b00;
            tick();
            check("s4b_hold", {30'd0, hold_a}, 32'd0);
            check("s4b_fall", {30'd0, fall_a}, (c == 18) ? 32'd1 : 32'd0);
        end

        // Reset during lock, input still high afterwards
        start("s5");
        for (int k = 0; k < 24; k++) begin
            if (c == 10) in_data = 2'b01;
            if (c == 15) reset = 1'b1;
            if (c == 17) reset = 1'b0;
            tick();
            check("s5_level", {30'd0, level_a},
                  ((c >= 13 && c < 16) || c >= 20) ? 32'd1 : 32'd0);
            check("s5_rise", {30'd0, rise_a}, (c == 13 || c == 20) ? 32'd1 : 32'd0);
            check("s5_fall", {30'd0, fall_a}, 32'd0);
        end

`ifdef MULTI_DEBOUNCER_IRQ_EN
        // Only ch0 is unmasked; clear coinciding with a new ch0 event loses to the set
        start("s6");
        irq_mask = 2'b01;
        for (int k = 0; k < 24; k++) begin
            irq_clear = 2'b00;
            if (c == 10) in_data = 2'b11;
            if (c == 14) in_data = 2'b10;
            if (c == 17 || c == 20) irq_clear = 2'b01;
            tick();
            check("s6_fall", {30'd0, fall_a}, (c == 17) ? 32'd1 : 32'd0);
            check("s6_pending", {30'd0, pending_a}, (c >= 14 && c < 21) ? 32'd1 : 32'd0);
            check("s6_irq", {31'd0, irq_a}, (c >= 15 && c < 22) ? 32'd1 : 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised multi-channel debouncer for push-buttons, limit switches and encoder contacts.
- Each channel has its own CDC synchroniser, per-channel lock-out counter and per-channel long-press timer.
- Outputs per channel: a clean level, one-cycle rise/fall pulses, and a one-cycle hold pulse.
- Sits between raw board pins and the control/register logic; replaces per-pin single debouncer instances.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- DELAY, 1500000, lock-out length in clk cycles after an accepted edge (>=2).
- CNT_W, 21, lock-out counter width; requires DELAY-1 < 2^CNT_W.
- HOLD_DELAY, 50000000, cycles the debounced level must stay 1 before the hold pulse fires (>=1).
- HOLD_W, 26, hold counter width; requires HOLD_DELAY < 2^HOLD_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  CHANNELS  raw asynchronous inputs.
- level  out  CHANNELS  debounced level.
- rise  out  CHANNELS  one-cycle pulse on accepted 0->1.
- fall  out  CHANNELS  one-cycle pulse on accepted 1->0.
- hold  out  CHANNELS  one-cycle pulse when level has been 1 for HOLD_DELAY cycles.
- any_event  out  1  OR of rise|fall|hold, same cycle.

Behaviour:
- Synchroniser: two flops per channel (s1, s2); s2 is the sampled input. Reset value 0.
- Per-channel FSM, two states:
  - IDLE: if s2 != level, then next cycle: level <= s2; rise or fall = 1 for exactly one cycle; lock counter <= DELAY-1; go to LOCK.
  - LOCK: counter decrements by 1 each cycle and s2 is ignored. When the counter is 0, go to IDLE.
- Lock-out timing: total lock duration is DELAY cycles. The next change can be accepted no earlier than DELAY cycles after the previous level change.
- Latency: in_data edge to level/rise/fall is 3 clk cycles (2 sync + 1 register).
- Input different from level when LOCK ends: the new edge is accepted on the first IDLE cycle. Glitches shorter than the lock window are therefore filtered only while locked; a level change that persists past lock end is always reflected.
- Hold timer:
  - Cleared to 0 whenever level==0 or in the rise cycle; otherwise increments while level==1.
  - When the count reaches HOLD_DELAY-1, hold pulses for one cycle.
  - Counter then saturates; no repeat until level falls and rises again.
  - A fall before HOLD_DELAY cancels the hold with no pulse.
- Channels are fully independent; simultaneous edges on several channels each produce their own pulses in the same cycle.
- rise and fall are never both 1 on one channel in one cycle. hold and rise never coincide, since HOLD_DELAY>=1.
- Reset (any time, including mid-lock or mid-hold):
  - s1, s2, level, rise, fall, hold, any_event and all counters go to 0; all FSMs go to IDLE.
  - An input held at 1 through reset yields rise 3 cycles after reset deasserts.
- All outputs are registered; no combinational path from in_data.

Optional Feature:
- Macro: MULTI_DEBOUNCER_IRQ_EN.
- With the macro defined:
  - Adds ports irq_mask (in, CHANNELS), irq_clear (in, CHANNELS), pending (out, CHANNELS), irq (out, 1).
  - pending[i] sets on rise|fall|hold of channel i when irq_mask[i]=1. It clears on irq_clear[i]=1; set wins over clear in the same cycle.
  - irq = |pending, registered (1 cycle after pending).
  - Reset clears pending and irq.
- Without the macro: these ports and registers do not exist; the rest of the behaviour is identical.

Test Plan:
- DELAY=4, CHANNELS=2; ch0 0->1 at cycle 10, held -> level[0]=1 and rise[0]=1 at cycle 13 only; ch1 stays 0 with no pulses.
- DELAY=8; ch0 rises at 10, toggles 1/0/1 at cycles 14–16, then settles 1 -> single rise at 13, no fall, level stays 1.
- DELAY=4; ch0 rises at 10, falls at 12 and stays 0 -> rise at 13, fall at 17 (first IDLE cycle), level 0 afterwards.
- HOLD_DELAY=10; ch0 rises and holds -> rise at cycle t, hold exactly once 10 cycles later. Second run: fall 5 cycles after rise -> no hold pulse.
- Reset asserted at cycle 15, while ch0 is locked after a rise at 13 -> all outputs 0 at 16. in_data still 1 -> rise 3 cycles after reset deasserts.
- With MULTI_DEBOUNCER_IRQ_EN: irq_mask=01; ch0 and ch1 both rise -> pending=01 and irq=1 one cycle later. irq_clear=01 in the same cycle as a new ch0 fall -> pending[0] stays 1.
